// File: rtl/regfile_writeback.sv
// Write-back stage: merges ALU results with FIFO-buffered load results onto the
// register-file write port and tracks outstanding loads. Optional: REGFILE_WB_BYPASS_EN.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [31:0]      ld_data,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    output logic [31:0]      pending,
    output logic             write,
    output logic [4:0]       wrAddr,
    output logic [31:0]      wrData,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [4:0]       r_mem_rd   [DEPTH];
    logic [31:0]      r_mem_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_write;
    logic [4:0]       r_wr_addr;
    logic [31:0]      r_wr_data;
    logic [31:0]      r_pending;

    logic             w_full;
    logic             w_empty;
    logic             w_alu_sel;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_sel_valid;
    logic [4:0]       w_sel_rd;
    logic [31:0]      w_sel_data;
    logic [31:0]      w_clr_mask;
    logic [31:0]      w_set_mask;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_alu_sel = alu_valid && (alu_rd != 5'd0);

`ifdef REGFILE_WB_BYPASS_EN
    // Empty FIFO and idle ALU: a fresh load skips the queue entirely.
    assign w_bypass = !w_alu_sel && w_empty && ld_valid && (ld_rd != 5'd0);
`else
    assign w_bypass = 1'b0;
`endif

    // Pop only looks at the ALU; an x0 ALU write does not steal the port.
    assign w_pop  = !w_alu_sel && !w_empty;
    assign w_push = ld_valid && !w_full && (ld_rd != 5'd0) && !w_bypass;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = r_wr_addr;
        w_sel_data  = r_wr_data;
        w_clr_mask  = '0;
        if (w_alu_sel) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = r_mem_rd[r_rd_ptr];
            w_sel_data  = r_mem_data[r_rd_ptr];
            w_clr_mask  = 32'h1 << r_mem_rd[r_rd_ptr];
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = ld_rd;
            w_sel_data  = ld_data;
            w_clr_mask  = 32'h1 << ld_rd;
        end
    end

    assign w_set_mask = (issue_valid && (issue_rd != 5'd0)) ? (32'h1 << issue_rd) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_write   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_pending <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_write   <= w_sel_valid;
            r_wr_addr <= w_sel_rd;
            r_wr_data <= w_sel_data;
            // Set after clear so a re-issued load keeps its register pending.
            r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= ld_rd;
            r_mem_data[r_wr_ptr] <= ld_data;
        end
    end

    assign ld_ready   = !w_full;
    assign pending    = r_pending;
    assign write      = r_write;
    assign wrAddr     = r_wr_addr;
    assign wrData     = r_wr_data;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a behavioural model predicts each
// write-back, FIFO occupancy and pending mask; directed steps cover the corner cases.
module tb_regfile_writeback;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [31:0]      alu_data;
    logic             ld_valid;
    logic             ld_ready;
    logic [4:0]       ld_rd;
    logic [31:0]      ld_data;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [31:0]      pending;
    logic             write;
    logic [4:0]       wrAddr;
    logic [31:0]      wrData;
    logic [CNT_W-1:0] fifo_count;

    regfile_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending),
        .write(write), .wrAddr(wrAddr), .wrData(wrData), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [36:0] mq[$];
    logic [36:0] sb[$];
    logic [31:0] m_pending = '0;
    int          peak;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    // Predict this cycle from the current inputs, clock once, then compare.
    task automatic step();
        logic        alu_sel, byp, accept, exp_w;
        logic [36:0] head;
        logic [31:0] c_mask, s_mask;
        alu_sel = alu_valid && (alu_rd != 5'd0);
        byp     = BYP && !alu_sel && (mq.size() == 0) && ld_valid && (ld_rd != 5'd0);
        accept  = ld_valid && (mq.size() < DEPTH);
        c_mask  = '0;
        if (alu_sel) begin
            sb.push_back({alu_rd, alu_data});
        end else if (mq.size() > 0) begin
            head = mq.pop_front();
            sb.push_back(head);
            c_mask[head[36:32]] = 1'b1;
        end else if (byp) begin
            sb.push_back({ld_rd, ld_data});
            c_mask[ld_rd] = 1'b1;
        end
        if (accept && (ld_rd != 5'd0) && !byp) mq.push_back({ld_rd, ld_data});
        s_mask = '0;
        if (issue_valid && (issue_rd != 5'd0)) s_mask[issue_rd] = 1'b1;
        m_pending = ((m_pending & ~c_mask) | s_mask) & ~32'h1;
        exp_w = (sb.size() != 0);

        @(posedge clk);
        #1;
        check("write", 32'(write), 32'(exp_w));
        if (exp_w) begin
            head = sb.pop_front();
            if (write) begin
                check("wrAddr", 32'(wrAddr), 32'(head[36:32]));
                check("wrData", wrData, head[31:0]);
            end
        end
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("pending", pending, m_pending);
        check("ld_ready", 32'(ld_ready), 32'(mq.size() < DEPTH));
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    endtask

    initial begin
        int guard;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_write", 32'(write), 32'h0);
        check("rst_wrAddr", 32'(wrAddr), 32'h0);
        check("rst_wrData", wrData, 32'h0);
        check("rst_pending", pending, 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_ld_ready", 32'(ld_ready), 32'h1);

        // ALU only, then an x0 write that must not fire and must hold the port.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        check("t1_write", 32'(write), 32'h1);
        check("t1_addr", 32'(wrAddr), 32'd5);
        check("t1_data", wrData, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h11111111;
        step();
        check("t1_x0_write", 32'(write), 32'h0);
        check("t1_x0_hold", 32'(wrAddr), 32'd5);

        // Load queued behind a three-cycle ALU burst.
        peak = 0;
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'(i) * 32'h101;
            ld_valid = (i == 1); ld_rd = 5'd7; ld_data = 32'h1234;
            step();
        end
        idle_inputs();
        step();
        check("t2_last_addr", 32'(wrAddr), 32'd7);
        check("t2_peak", 32'(peak), 32'd1);

        // Fill the FIFO while the ALU is busy, refuse a fifth offer, then drain.
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'hA000 + 32'(i);
            ld_valid = 1'b1; ld_rd = 5'(8 + i); ld_data = 32'hB000 + 32'(i);
            step();
        end
        check("t3_full_ready", 32'(ld_ready), 32'h0);
        check("t3_full_count", 32'(fifo_count), 32'd4);
        alu_rd = 5'd24; ld_rd = 5'd12; ld_data = 32'hBAD;
        step();
        check("t3_fifth_count", 32'(fifo_count), 32'd4);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_drain_addr", 32'(wrAddr), 32'(8 + i));
        end

        // Scoreboard: set on issue, clear on write, set wins on collision.
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        check("t4_set", 32'(pending[9]), 32'h1);
        issue_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9999;
        guard = 0;
        do begin
            step();
            ld_valid = 1'b0;
            guard++;
        end while (!(write && wrAddr == 5'd9) && guard < 10);
        check("t4_wr_seen", 32'(guard < 10), 32'h1);
        check("t4_clear", 32'(pending[9]), 32'h0);
        issue_valid = 1'b1; issue_rd = 5'd9;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9A9A;
        guard = 0;
        do begin
            step();
            ld_valid = 1'b0;
            guard++;
        end while (!(write && wrAddr == 5'd9) && guard < 10);
        check("t4_wr2_seen", 32'(guard < 10), 32'h1);
        check("t4_set_wins", 32'(pending[9]), 32'h1);
        idle_inputs();
        step();
        check("t4_still_set", 32'(pending[9]), 32'h1);

        // Asynchronous reset with two loads queued and x4 pending.
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1'b0;
            alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'hC0 + 32'(i);
            ld_valid = 1'b1; ld_rd = 5'(4 + i); ld_data = 32'hD0 + 32'(i);
            step();
        end
        check("t5_pre_count", 32'(fifo_count), 32'd2);
        check("t5_pre_pend4", 32'(pending[4]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_write", 32'(write), 32'h0);
        check("t5_count", 32'(fifo_count), 32'h0);
        check("t5_pending", pending, 32'h0);
        check("t5_wrAddr", 32'(wrAddr), 32'h0);
        mq.delete(); sb.delete(); m_pending = '0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Load latency from an empty FIFO with an idle ALU.
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hCAFE;
        step();
        check("t6_cycle1_write", 32'(write), 32'(BYP));
        if (BYP) check("t6_cycle1_addr", 32'(wrAddr), 32'd12);
        idle_inputs();
        step();
        check("t6_cycle2_write", 32'(write), 32'(!BYP));
        check("t6_cycle2_addr", 32'(wrAddr), 32'd12);

        // Random mix: simultaneous push/pop, x0 traffic, issue/clear overlap.
        for (int i = 0; i < 300; i++) begin
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_rd      = 5'($urandom_range(0, 31));
            alu_data    = $urandom;
            ld_valid    = ($urandom_range(0, 1) == 0);
            ld_rd       = 5'($urandom_range(0, 31));
            ld_data     = $urandom;
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = 5'($urandom_range(0, 31));
            step();
        end
        idle_inputs();
        guard = 0;
        while (mq.size() > 0 && guard < 20) begin
            step();
            guard++;
        end
        check("final_empty", 32'(fifo_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back stage: the single writer driving the register file's write port (write, wrAddr, wrData).
- Merges single-cycle ALU results with variable-latency load results.
- Load results are buffered in a small FIFO and drained when the ALU is not writing.
- Keeps a 32-bit pending-load scoreboard so the issue stage can stall on registers whose loads have not yet been written back.

Parameters:
- DEPTH, 4: load-result FIFO entries; power of two, >= 2.
- CNT_W, 3: width of fifo_count; must hold DEPTH, so CNT_W = log2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  FIFO can accept; equals !full
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- issue_valid  in  1  load instruction issued this cycle
- issue_rd  in  5  destination of the issued load
- pending  out  32  bit i = load to xi outstanding; bit 0 is always 0
- write  out  1  register-file write enable
- wrAddr  out  5  register-file write address
- wrData  out  32  register-file write data
- fifo_count  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset (async, rst_n low):
  - write=0, wrAddr=0, wrData=0, pending=0, fifo_count=0, FIFO pointers=0.
  - ld_ready=1 once reset deasserts.
  - Any in-flight result is discarded.
- Load accept: handshake when ld_valid & ld_ready at a rising edge.
  - ld_rd != 0: the {rd, data} entry is pushed to the FIFO tail.
  - ld_rd == 0: the entry is accepted and dropped; no push.
- ld_ready is !full only. A pop in the same cycle does not free space for a push while full.
- Output select each cycle, registered at the edge; write/wrAddr/wrData are outputs of flops:
  1. alu_valid & alu_rd != 0: load the ALU result; write=1.
  2. Otherwise, FIFO non-empty: pop the head and load it; write=1.
  3. Otherwise: write=0. wrAddr and wrData hold their previous values.
- ALU writes to x0 are dropped, and they do not block a FIFO pop that cycle.
- Latency:
  - ALU: sampled at edge k, write asserted after edge k.
  - Load through FIFO: pushed at edge k, earliest write after edge k+1 (2 cycles).
- Ordering: FIFO entries drain strictly in push order. The ALU always has priority; loads may starve while the ALU is busy every cycle.
- Simultaneous push and pop (not full): both occur; fifo_count is unchanged.
- Pointers wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
- Scoreboard:
  - issue_valid & issue_rd != 0 sets pending[issue_rd] at the edge.
  - A load-sourced write of register r clears pending[r] at the same edge the write is registered.
  - Set and clear of the same register in one cycle: set wins (a new load was issued).
  - ALU writes never touch pending.
- fifo_count is registered and matches occupancy after each edge.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - When the FIFO is empty, no ALU write is selected, and ld_valid & ld_rd != 0, the load result goes directly to the output registers.
  - Latency is 1 cycle; no push occurs; pending is cleared as for a popped entry.
- Undefined: every load result passes through the FIFO (2-cycle minimum latency).

Test Plan:
1. ALU only: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF -> next cycle write=1, wrAddr=5, wrData=32'hDEADBEEF; alu_rd=0 -> write=0.
2. Load behind ALU burst: ld x7=32'h1234 while alu_valid for 3 cycles (x1..x3).
   - Required: writes x1, x2, x3, then x7.
   - fifo_count peaks at 1.
3. FIFO full: 4 loads x8..x11 pushed with ALU busy -> ld_ready=0, fifo_count=4, a 5th offer is not accepted; ALU idle -> drains x8..x11 in order.
4. Scoreboard: issue x9 -> pending[9]=1; load x9 returns and is written -> pending[9]=0. Issue x9 in the same cycle as the write of x9 -> pending[9] stays 1.
5. Reset mid-operation: 2 entries queued and pending[4]=1, pull rst_n low -> write=0, fifo_count=0, pending=0 immediately, without waiting for a clock edge.
6. With REGFILE_WB_BYPASS_EN: FIFO empty, ALU idle, ld x12=32'hCAFE -> write=1, wrAddr=12 after 1 cycle; without the macro, after 2 cycles.
